grey_pingpong_fb: RTL

- Consumes the quarter-rate pixel strobe, 8-bit grey value and 160x120 linear address produced by the HD divide-by-4 downsampler.
- Stores each complete grey frame into one half of a two-bank on-chip frame buffer.
- Hands finished frames to the downstream stereo/disparity reader via a ready/release handshake, so the writer never overwrites a frame being read.

---
 rtl/grey_pingpong_fb.sv | 116 +++++++++++
 1 files changed

// File: rtl/grey_pingpong_fb.sv
`default_nettype none
// ============================================================================
// grey_pingpong_fb : two-bank ping-pong grey frame buffer with reader handshake
// Revision 1.0
// ============================================================================
module grey_pingpong_fb #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int DW    = 8,
  parameter int AW    = 15
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] in_grey,
  input  logic [AW-1:0] in_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_en,
  input  logic          rd_done,
  output logic [DW-1:0] rd_data,
  output logic          frame_rdy,
  output logic          rd_bank,
  output logic          wr_bank,
  output logic [7:0]    frame_cnt,
  output logic [7:0]    drop_cnt
);

  localparam int          N     = IMG_W * IMG_H;
  localparam int          IW    = $clog2(N);
  localparam logic [AW:0] N_EXT = (AW+1)'(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    WRITE    = 1'b1
  } state_t;

  state_t state;

  logic [DW-1:0] bank0 [N];
  logic [DW-1:0] bank1 [N];

  logic          sof_hit;
  logic          in_range;
  logic          rd_in_range;
  logic          wr_en;
  logic          eof;
  logic          publish;
  logic          restart;
  logic          drop_ev;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  always_comb begin
    sof_hit     = in_vld && (in_addr == '0);
    in_range    = {1'b0, in_addr} < N_EXT;
    rd_in_range = {1'b0, rd_addr} < N_EXT;
    wr_idx      = in_addr[IW-1:0];
    rd_idx      = rd_addr[IW-1:0];
    // Out-of-range strobes are the upstream address overflow and never touch RAM
    wr_en       = !rst && in_vld &&
                  (((state == WAIT_SOF) && (in_addr == '0)) ||
                   ((state == WRITE) && in_range));
    eof         = (state == WRITE) && in_vld && (in_addr == LAST);
    publish     = eof && (!frame_rdy || rd_done);
    restart     = (state == WRITE) && sof_hit;
    drop_ev     = restart || (eof && !publish);
  end

  always_ff @(posedge pclk) begin
    if (wr_en && !wr_bank) bank0[wr_idx] <= in_grey;
    if (wr_en &&  wr_bank) bank1[wr_idx] <= in_grey;
  end

  // Read-first registered port; only the published bank is ever read
  always_ff @(posedge pclk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (!rd_in_range)  rd_data <= '0;
      else if (rd_bank)  rd_data <= bank1[rd_idx];
      else               rd_data <= bank0[rd_idx];
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= WAIT_SOF;
      frame_rdy <= 1'b0;
      rd_bank   <= 1'b0;
      wr_bank   <= 1'b0;
      frame_cnt <= 8'd0;
      drop_cnt  <= 8'd0;
    end else begin
      case (state)
        WAIT_SOF: if (sof_hit) state <= WRITE;
        WRITE:    if (eof)     state <= WAIT_SOF;
        default:               state <= WAIT_SOF;
      endcase

      // A publish coinciding with a release keeps the frame held on the new bank
      if (publish) begin
        rd_bank   <= wr_bank;
        wr_bank   <= ~wr_bank;
        frame_rdy <= 1'b1;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (rd_done) begin
        frame_rdy <= 1'b0;
      end

      if (drop_ev && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire
